// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALUctr codes and FSM encoding.
package alu_arbiter_pkg;
  localparam logic [2:0] CTR_ADDU = 3'b000;
  localparam logic [2:0] CTR_ADD  = 3'b001;
  localparam logic [2:0] CTR_OR   = 3'b010;
  localparam logic [2:0] CTR_SUBU = 3'b100;
  localparam logic [2:0] CTR_SUB  = 3'b101;
  localparam logic [2:0] CTR_SLTU = 3'b110;
  localparam logic [2:0] CTR_SLT  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/alu_arbiter_if.sv
// Requester/response bundle between the arbiter (slave) and its clients (master).
interface alu_arbiter_if #(parameter int WIDTH = 32);
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [2:0]       req0_ctr;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [2:0]       req1_ctr;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
  logic [WIDTH-1:0] rsp_result;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctr,
    input  req1_valid, req1_a, req1_b, req1_ctr, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, busy
  );
  modport master (
    output req0_valid, req0_a, req0_b, req0_ctr,
    output req1_valid, req1_a, req1_b, req1_ctr, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, busy
  );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Single-adder ALU: subtract and both compares reuse the one adder via inverted B + carry-in.
module alu_arbiter_alu import alu_arbiter_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       ctr_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);
  logic             sub, cout, ovf, lt;
  logic [WIDTH-1:0] bx, sum;

  always_comb begin
    sub = ctr_i[2];
    bx  = sub ? ~b_i : b_i;
    {cout, sum} = {1'b0, a_i} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
    ovf = (a_i[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    // ctr[0] selects signed compare; unsigned a<b shows up as a missing carry
    lt  = ctr_i[0] ? (sum[WIDTH-1] ^ ovf) : ~cout;
    result_o = sum;
    if (ctr_i == CTR_OR)
      result_o = a_i | b_i;
    else if (ctr_i[2:1] == 2'b11)
      result_o = {{(WIDTH-1){1'b0}}, lt};
  end

  assign zero_o = (result_o == '0);
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter feeding one shared ALU: IDLE grants, EXEC computes, RESP holds until taken.
module alu_arbiter import alu_arbiter_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);
  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [2:0]       ctr_q;
  logic             id_q, zero_q;
  logic             gnt_id, accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;

  // lone valid wins; on contention the pointer decides
  assign gnt_id = (bus.req0_valid & bus.req1_valid) ? ptr_q : bus.req1_valid;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.req0_valid | bus.req1_valid) begin
        accept  = 1'b1;
        ptr_d   = ~gnt_id;
        state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req0_ready = accept & ~rst & ~gnt_id;
  assign bus.req1_ready = accept & ~rst &  gnt_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctr_q   <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (accept) begin
        a_q   <= gnt_id ? bus.req1_a   : bus.req0_a;
        b_q   <= gnt_id ? bus.req1_b   : bus.req0_b;
        ctr_q <= gnt_id ? bus.req1_ctr : bus.req0_ctr;
        id_q  <= gnt_id;
      end
      if (state_q == ST_EXEC) begin
        res_q  <= alu_res;
        zero_q <= alu_zero;
      end
    end
  end

  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .ctr_i    (ctr_q),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );

  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scenarios plus random traffic against a transaction-level reference model.
module tb_alu_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W)) bus ();
  alu_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic         v [2];
  logic [W-1:0] a [2];
  logic [W-1:0] b [2];
  logic [2:0]   c [2];
  logic         rr;

  assign bus.req0_valid = v[0];
  assign bus.req0_a     = a[0];
  assign bus.req0_b     = b[0];
  assign bus.req0_ctr   = c[0];
  assign bus.req1_valid = v[1];
  assign bus.req1_a     = a[1];
  assign bus.req1_b     = b[1];
  assign bus.req1_ctr   = c[1];
  assign bus.rsp_ready  = rr;

  int n_tot = 0, n_bad = 0;

  // model: one op in flight at most; response due from 2 cycles after accept
  bit           m_inflight = 0;
  bit           m_ptr = 0;
  int           m_age = 0;
  int           m_last_gnt = -1;
  int           m_exp_id;
  logic [W-1:0] m_exp_res;
  logic         m_exp_zero;
  int           gnt_log [$];
  logic [W-1:0] obs_res [$];
  int           obs_id  [$];
  logic         obs_zero[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [2:0] op);
    case (op)
      3'b010:         return x | y;
      3'b100, 3'b101: return x - y;
      3'b110:         return (x < y) ? 1 : 0;
      3'b111:         return ($signed(x) < $signed(y)) ? 1 : 0;
      default:        return x + y;
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return W'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2:0] op);
    v[i] = 1'b1; a[i] = x; b[i] = y; c[i] = op;
  endtask

  // inputs are already driven for this cycle; check, advance model across the edge
  task automatic step();
    int g;
    logic [1:0] exp_rdy;
    bit rsp_due;
    #1;
    g = -1;
    if (!rst && !m_inflight && (v[0] || v[1]))
      g = (v[0] && v[1]) ? int'(m_ptr) : (v[1] ? 1 : 0);
    exp_rdy = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
    rsp_due = m_inflight && (m_age >= 2);
    chk("ready", {bus.req1_ready, bus.req0_ready}, exp_rdy);
    chk("busy", bus.busy, m_inflight);
    chk("rsp_valid", bus.rsp_valid, rsp_due);
    if (rsp_due) begin
      chk("rsp_id", bus.rsp_id, m_exp_id[0]);
      chk("rsp_result", bus.rsp_result, m_exp_res);
      chk("rsp_zero", bus.rsp_zero, m_exp_zero);
      if (rr && !rst) begin
        obs_res.push_back(bus.rsp_result);
        obs_id.push_back(int'(bus.rsp_id));
        obs_zero.push_back(bus.rsp_zero);
      end
    end
    m_last_gnt = -1;
    if (rst) begin
      m_inflight = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_inflight = 1; m_age = 1; m_exp_id = g;
      m_exp_res  = ref_alu(a[g], b[g], c[g]);
      m_exp_zero = (m_exp_res == '0);
      m_ptr      = (g == 0);
      gnt_log.push_back(g);
      m_last_gnt = g;
    end else if (m_inflight) begin
      if (m_age >= 2 && rr) m_inflight = 0;
      else m_age++;
    end
    @(posedge clk);
    @(negedge clk);
    if (m_last_gnt >= 0) v[m_last_gnt] = 1'b0;
    // idle requesters scribble on their operands to prove the captured copy is used
    for (int i = 0; i < 2; i++)
      if (!v[i]) begin a[i] = $urandom; b[i] = $urandom; c[i] = 3'($urandom); end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_inflight || v[0] || v[1]) && n < 40) begin step(); n++; end
    if (m_inflight || v[0] || v[1]) chk("drain_timeout", 1, 0);
  endtask

  task automatic clr_obs();
    obs_res.delete(); obs_id.delete(); obs_zero.delete(); gnt_log.delete();
  endtask

  initial begin
    int k;
    v[0] = 0; v[1] = 0; rr = 1;
    for (int i = 0; i < 2; i++) begin a[i] = '0; b[i] = '0; c[i] = '0; end
    rst = 1;
    @(negedge clk);
    step(); step();
    rst = 0;
    #1;
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_id", bus.rsp_id, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_zero", bus.rsp_zero, 0);
    chk("rst_busy", bus.busy, 0);

    // single subu
    clr_obs();
    set_op(0, 5, 7, 3'b100);
    drain();
    chk("single_n", obs_res.size(), 1);
    if (obs_res.size() > 0) begin
      chk("single_res", obs_res[0], 32'hFFFF_FFFE);
      chk("single_id", obs_id[0], 0);
      chk("single_zero", obs_zero[0], 0);
    end

    // contention straight out of reset
    rst = 1; step(); rst = 0;
    clr_obs();
    set_op(0, 32'hF0, 32'h0F, 3'b010);
    set_op(1, 32'hFFFF_FFFF, 1, 3'b111);
    drain();
    chk("cont_n", obs_res.size(), 2);
    if (obs_res.size() == 2) begin
      chk("cont_id0", obs_id[0], 0);
      chk("cont_res0", obs_res[0], 32'hFF);
      chk("cont_id1", obs_id[1], 1);
      chk("cont_res1", obs_res[1], 1);
    end

    // fairness: both requesters kept busy for 6 grants
    clr_obs();
    k = 0;
    while (gnt_log.size() < 6 && k < 60) begin
      for (int i = 0; i < 2; i++)
        if (!v[i]) set_op(i, rnd_val(), rnd_val(), 3'($urandom_range(0, 7)));
      step(); k++;
    end
    v[0] = 0; v[1] = 0;
    drain();
    chk("fair_n", gnt_log.size(), 6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++) chk("fair_gnt", gnt_log[i], i % 2);

    // backpressure on a sltu result of 0
    clr_obs();
    rr = 0;
    set_op(1, 32'hFFFF_FFFF, 1, 3'b110);
    step();
    set_op(0, 32'h11, 32'h22, 3'b000);
    k = 0;
    while (!bus.rsp_valid && k < 10) begin step(); k++; end
    for (int i = 0; i < 4; i++) step();
    rr = 1;
    drain();
    chk("bp_n", obs_res.size(), 2);
    if (obs_res.size() == 2) begin
      chk("bp_id", obs_id[0], 1);
      chk("bp_res", obs_res[0], 0);
      chk("bp_id_next", obs_id[1], 0);
    end

    // zero flag
    clr_obs();
    set_op(0, 32'h1234, 32'h1234, 3'b100);
    drain();
    if (obs_res.size() > 0) begin
      chk("zero_res", obs_res[0], 0);
      chk("zero_flag", obs_zero[0], 1);
    end else chk("zero_n", 0, 1);

    // reset during EXEC drops the op and re-arms the pointer at requester 0
    clr_obs();
    set_op(0, 3, 4, 3'b000);
    step();
    rst = 1; step(); rst = 0;
    set_op(0, 9, 1, 3'b101);
    set_op(1, 9, 2, 3'b101);
    step();
    chk("rexec_gnt", gnt_log[gnt_log.size()-1], 0);
    drain();
    chk("rexec_n", obs_res.size(), 2);
    if (obs_res.size() == 2) chk("rexec_res0", obs_res[0], 8);

    // random traffic, backpressure and occasional reset
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++)
        if (!v[i] && $urandom_range(0, 2) == 0)
          set_op(i, rnd_val(), rnd_val(), 3'($urandom_range(0, 7)));
      rr  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 0; rr = 1;
    drain();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
